// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit memory controller.
//   - default widths (word and byte-offset)
//   - RV32 funct3 size/sign encodings
//   - controller state type
//   - alignment check helper
package lsu_pkg;

    localparam int LSU_XLEN  = 32;
    localparam int LSU_BADDR = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } lsu_state_t;

    // Returns 1 when the access must be rejected without touching memory:
    // a misaligned halfword/word, an unsigned size on a store, or any
    // undefined size code.
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = offset[0];
            F3_W:    bad = (offset != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | offset[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword from a memory word and
// sign- or zero-extends it to XLEN.
//   word   in  XLEN   raw memory word (byte k in bits [8k+7:8k])
//   offset in  BADDR  byte offset of the access within the word
//   funct3 in  3      RV32 load size/sign code
//   result out XLEN   extended load data (0 for an undefined code)
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = LSU_XLEN,
    parameter int BADDR = LSU_BADDR
) (
    input  logic [XLEN-1:0]  word,
    input  logic [BADDR-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension; the halfword lane ignores offset[0]
    // because halfword accesses are already known to be aligned.
    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        half_s = word[{offset[BADDR-1:1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_s};
            F3_H:    result = {{(XLEN-16){half_s[15]}}, half_s};
            F3_HU:   result = {{(XLEN-16){1'b0}}, half_s};
            F3_W:    result = word;
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for a byte-addressable data memory with
// a one-cycle registered read.
//   clk, nrst                      clock / async active-low reset
//   req_valid/req_ready            request handshake from execute
//   req_we, req_funct3, req_addr,  store flag, RV32 size/sign, byte address,
//   req_wdata                      low-justified store data
//   rsp_valid/rsp_ready            response handshake to writeback
//   rsp_rdata, rsp_err             extended load data (0 for stores), error
//   mem_addr, mem_wdata            memory address / unshifted write data
//   mem_gwe, mem_rd, mem_bw0..3    word write, read, byte-lane write enables
//   mem_rdata                      memory read data, valid one cycle after mem_rd
// All outputs are registered; memory strobes are high only in ACCESS.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN  = LSU_XLEN,
    parameter int BADDR = LSU_BADDR
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_err,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic             mem_gwe,
    output logic             mem_rd,
    output logic             mem_bw0,
    output logic             mem_bw1,
    output logic             mem_bw2,
    output logic             mem_bw3,
    input  logic [XLEN-1:0]  mem_rdata
);

    lsu_state_t        state_r;
    lsu_state_t        next_state_s;
    logic              accept_s;
    logic              misaligned_s;
    logic              gwe_next_s;
    logic              rd_next_s;
    logic [3:0]        bw_next_s;
    logic [3:0]        bw_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [XLEN-1:0]   load_data_s;

    assign misaligned_s = is_misaligned(req_we, req_funct3, req_addr[1:0]);

    // The memory is presented the registered request directly.
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_bw0   = bw_r[0];
    assign mem_bw1   = bw_r[1];
    assign mem_bw2   = bw_r[2];
    assign mem_bw3   = bw_r[3];

    lsu_load_align #(
        .XLEN  (XLEN),
        .BADDR (BADDR)
    ) u_load_align (
        .word   (mem_rdata),
        .offset (addr_r[BADDR-1:0]),
        .funct3 (funct3_r),
        .result (load_data_s)
    );

    // Next-state logic; a request is only taken in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = misaligned_s ? S_RESP : S_ACCESS;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ACCESS:  next_state_s = we_r ? S_RESP : S_CAPTURE;
            S_CAPTURE: next_state_s = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default:   next_state_s = S_IDLE;
        endcase
    end

    // Strobe decode for the cycle about to be spent in ACCESS. Strobes are
    // registered, so they are computed from the request on the accept edge.
    always_comb begin
        gwe_next_s = 1'b0;
        rd_next_s  = 1'b0;
        bw_next_s  = 4'b0000;
        if (accept_s && !misaligned_s) begin
            if (req_we) begin
                case (req_funct3)
                    F3_W:    gwe_next_s = 1'b1;
                    F3_H:    bw_next_s  = req_addr[1] ? 4'b1100 : 4'b0011;
                    F3_B:    bw_next_s  = 4'b0001 << req_addr[1:0];
                    default: bw_next_s  = 4'b0000;
                endcase
            end else begin
                rd_next_s = 1'b1;
            end
        end else begin
            gwe_next_s = 1'b0;
            rd_next_s  = 1'b0;
            bw_next_s  = 4'b0000;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture, memory strobes and response registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {XLEN{1'b0}};
            mem_gwe   <= 1'b0;
            mem_rd    <= 1'b0;
            bw_r      <= 4'b0000;
            we_r      <= 1'b0;
            funct3_r  <= 3'b000;
            addr_r    <= {XLEN{1'b0}};
            wdata_r   <= {XLEN{1'b0}};
        end else begin
            req_ready <= (next_state_s == S_IDLE);
            rsp_valid <= (next_state_s == S_RESP);
            mem_gwe   <= gwe_next_s;
            mem_rd    <= rd_next_s;
            bw_r      <= bw_next_s;
            if (accept_s) begin
                we_r      <= req_we;
                funct3_r  <= req_funct3;
                addr_r    <= req_addr;
                wdata_r   <= req_wdata;
                rsp_err   <= misaligned_s;
                rsp_rdata <= {XLEN{1'b0}};
            end else if (state_r == S_CAPTURE) begin
                rsp_rdata <= load_data_s;
            end else if ((state_r == S_RESP) && rsp_ready) begin
                rsp_err <= 1'b0;
            end else begin
                rsp_err   <= rsp_err;
                rsp_rdata <= rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed, self-checking bench for lsu_mem_ctrl with a
// byte-addressable memory model and a response scoreboard.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gwe;
    logic        mem_rd;
    logic        mem_bw0, mem_bw1, mem_bw2, mem_bw3;
    logic [31:0] mem_rdata;

    logic [5:0]  strb_s;
    assign strb_s = {mem_gwe, mem_rd, mem_bw3, mem_bw2, mem_bw1, mem_bw0};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] mem_q [0:255];

    lsu_mem_ctrl dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gwe    (mem_gwe),
        .mem_rd     (mem_rd),
        .mem_bw0    (mem_bw0),
        .mem_bw1    (mem_bw1),
        .mem_bw2    (mem_bw2),
        .mem_bw3    (mem_bw3),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read of the aligned word; writes land on the
    // lanes named by the strobes, taking data from the low end of data_in.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= {mem_q[{mem_addr[7:2], 2'd3}], mem_q[{mem_addr[7:2], 2'd2}],
                          mem_q[{mem_addr[7:2], 2'd1}], mem_q[{mem_addr[7:2], 2'd0}]};
        end
        for (int k = 0; k < 4; k++) begin
            if (mem_gwe) begin
                mem_q[{mem_addr[7:2], k[1:0]}] <= mem_wdata[8*k +: 8];
            end else if (strb_s[k] && (k >= int'(mem_addr[1:0]))) begin
                mem_q[{mem_addr[7:2], k[1:0]}] <= mem_wdata[8*(k - int'(mem_addr[1:0])) +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One request through to its handshake. exp_strb = {gwe, rd, bw3..bw0}
    // expected in ACCESS. Latency is counted in edges including the
    // accepting edge: misaligned 1, store 2, load 3.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [5:0] exp_strb, input int hold);
        exp_t e;
        exp_t got_e;
        int edges;
        logic [5:0] strb_acc;
        logic [31:0] held_rdata;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : (we ? 2 : 3);
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        edges    = 1;
        strb_acc = 6'd0;
        @(negedge clk);
        if (!exp_err) begin
            chk("access_strobes", {26'd0, strb_s}, {26'd0, exp_strb});
            chk("access_addr", mem_addr, addr);
            if (we) chk("access_wdata", mem_wdata, wdata);
        end
        while (!rsp_valid && edges < 20) begin
            strb_acc |= strb_s;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        strb_acc |= strb_s;
        if (exp_err) chk("misaligned_no_strobe", {26'd0, strb_acc}, 32'd0);
        got_e = sb_q.pop_front();
        chk("latency", edges, got_e.lat);
        chk("rsp_rdata", rsp_rdata, got_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, got_e.err});
        held_rdata = got_e.rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, held_rdata);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_err", {31'd0, rsp_err}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_q[a] = 8'h00;
        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_strobes", {26'd0, strb_s}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        nrst = 1'b1;

        // word store/load
        do_req(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 6'b10_0000, 0);
        do_req(1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 6'b01_0000, 0);
        // byte store to lane 3, signed and unsigned readback
        do_req(1'b1, F3_B,  32'h13, 32'h80,       32'h0,        1'b0, 6'b00_1000, 0);
        do_req(1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 6'b01_0000, 0);
        do_req(1'b0, F3_BU, 32'h13, 32'h0,        32'h00000080, 1'b0, 6'b01_0000, 0);
        do_req(1'b0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 6'b01_0000, 0);
        do_req(1'b0, F3_HU, 32'h12, 32'h0,        32'h000080AD, 1'b0, 6'b01_0000, 0);
        // halfword store to upper half
        do_req(1'b1, F3_H,  32'h22, 32'h8001,     32'h0,        1'b0, 6'b00_1100, 0);
        do_req(1'b0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, 6'b01_0000, 0);
        do_req(1'b0, F3_HU, 32'h22, 32'h0,        32'h00008001, 1'b0, 6'b01_0000, 0);
        // byte store to lane 1 with a positive value
        do_req(1'b1, F3_B,  32'h21, 32'h7F,       32'h0,        1'b0, 6'b00_0010, 0);
        do_req(1'b0, F3_B,  32'h21, 32'h0,        32'h0000007F, 1'b0, 6'b01_0000, 0);
        // rejected accesses
        do_req(1'b0, F3_W,  32'h05, 32'h0,        32'h0,        1'b1, 6'b00_0000, 0);
        do_req(1'b1, F3_H,  32'h03, 32'h1234,     32'h0,        1'b1, 6'b00_0000, 0);
        do_req(1'b0, 3'b011, 32'h00, 32'h0,       32'h0,        1'b1, 6'b00_0000, 0);
        do_req(1'b1, F3_BU, 32'h00, 32'h55,       32'h0,        1'b1, 6'b00_0000, 0);
        // backpressure: byte 0x13 was overwritten with 0x80 above
        do_req(1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 6'b01_0000, 5);

        // reset during ACCESS of a word store
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h40;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_access_gwe", {31'd0, mem_gwe}, 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk("abort_strobes", {26'd0, strb_s}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        end
        // the aborted store never reached memory
        do_req(1'b0, F3_W,  32'h40, 32'h0,        32'h00000000, 1'b0, 6'b01_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
